instruction_encoder: RTL
========================

// Module: instruction_encoder
// PURPOSE
//  Encodes ALU-op requests (op code + rd/rs1/rs2/imm) into 32-bit RV32 words for the custom subset
//  (ADD, SUB, SHIFTL, SHIFTR, ADDI, SUBI, NOOP) that the core's instruction decoder consumes.
//  Sits between the test/program sequencer and instruction memory. Each emitted word is tagged
//  with a sequential word address for direct memory write. Valid/ready on both sides, 2-entry output skid buffer.
// PARAMETERS
//  ADDR_W   8   width of instr_addr word counter; wraps at 2**ADDR_W
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       synchronous, active-low reset
//  op_valid    in   1       request valid
//  op_ready    out  1       encoder can accept request
//  op_code     in   3       000 NOOP, 010 ADD, 011 SUB, 100 SHIFTL, 101 SHIFTR, 110 ADDI, 111 SUBI; 001 illegal
//  rd          in   5       destination register
//  rs1         in   5       source register 1
//  rs2         in   5       source register 2 (R-type only)
//  imm         in   12      immediate (I-type only), two's complement, placed verbatim in [31:20]
//  instr_valid out  1       instr/instr_addr valid
//  instr_ready in   1       downstream accepts word
//  instr       out  32      encoded instruction
//  instr_addr  out  ADDR_W  word address of instr
//  err         out  1       sticky: illegal op seen (plus x0 guard hit when enabled)
//  err_clr     in   1       clears err; a same-cycle new error wins (err stays 1)
//  addr_wrap   out  1       sticky: instr_addr wrapped to 0; cleared only by reset
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): buffer empty, instr_valid=0, instr=0, instr_addr=0, err=0, addr_wrap=0,
//    op_ready=1 from first cycle after reset. Reset mid-transfer discards buffered words.
//  - Encoding (R-type opcode 0110011, I-type 0010011):
//    ADD {7'h00,rs2,rs1,3'b000,rd,op}; SUB {7'h20,rs2,rs1,3'b000,rd,op};
//    SHIFTL {7'h00,rs2,rs1,3'b001,rd,op}; SHIFTR {7'h00,rs2,rs1,3'b101,rd,op};
//    ADDI {imm,rs1,3'b000,rd,op}; SUBI {imm,rs1,3'b001,rd,op}; NOOP 32'h00000013.
//    Unused fields (rs2/imm) ignored.
//  - Illegal op_code 001: emits NOOP word (consumes an address) and sets err.
//  - Handshake: op accepted when op_valid&op_ready; word leaves when instr_valid&instr_ready.
//    instr/instr_addr held stable while instr_valid=1 and instr_ready=0.
//  - Latency 1: word accepted at edge N is at the output head from cycle N+1 if the buffer was empty.
//  - Buffer 2 entries; op_ready = (count<2), registered (no comb path from instr_ready).
//    Simultaneous accept+emit keeps count. With count==2, op_ready=0 regardless of instr_ready.
//  - Throughput 1 word/cycle when instr_ready stays high.
//  - instr_addr assigned at input acceptance from a write counter. Counter increments per accepted op
//    and wraps 2**ADDR_W-1 -> 0; the wrapping accept sets addr_wrap.
//  - Output order strictly FIFO.
// CONFIGURATION
//  INSTR_ENC_X0_GUARD_EN defined: non-NOOP op with rd==0 is emitted as NOOP 32'h00000013 and sets err.
//  Undefined: rd==0 encoded verbatim, no error.
// STRUCTURE
//  instr_pkg: opcode constants (OP, OP_IMM), funct3/funct7 values, 3-bit ALU op-code constants,
//    NOOP word; shared with instruction_decoder.
//  Sub-module instr_enc_skid: 2-entry valid/ready buffer, width 32+ADDR_W.
//  Encoder logic is a combinational function feeding the skid input.
// TESTING
//  1. ADD rd=3,rs1=1,rs2=2, instr_ready=1 -> next cycle instr=0x002081B3, addr=0; SUB same regs -> 0x402081B3, addr=1.
//  2. ADDI rd=5,rs1=0,imm=0xFFF -> 0xFFF00293; SUBI rd=5,rs1=1,imm=4 -> 0x00409293;
//     SHIFTR rd=4,rs1=4,rs2=1 -> 0x00125233; SHIFTL rd=6,rs1=2,rs2=3 -> 0x00311333.
//  3. Backpressure: instr_ready=0, 3 back-to-back ops -> op_ready drops after 2nd; head word stable;
//     release -> words emitted in order with addrs 0,1,2.
//  4. op_code=001 -> instr=0x00000013, err=1; err_clr=1 alone -> err=0 next cycle; err_clr with new illegal -> err=1.
//  5. ADDR_W=2: 5 ops -> addrs 0,1,2,3,0; addr_wrap=1 after 5th accept.
//  6. rst_n=0 with 2 buffered words -> instr_valid=0, instr_addr=0, err=0 next cycle.
//     X0_GUARD_EN: ADD rd=0 -> 0x00000013, err=1.

Source files
------------

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - RV32 custom-subset encodings and the ALU-op encode function
// Shared with instruction_decoder; keep field constants in sync with it.
package instr_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_SUBI    = 3'b001;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  localparam logic [31:0] NOOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    ALU_NOOP    = 3'b000,
    ALU_ILLEGAL = 3'b001,
    ALU_ADD     = 3'b010,
    ALU_SUB     = 3'b011,
    ALU_SHIFTL  = 3'b100,
    ALU_SHIFTR  = 3'b101,
    ALU_ADDI    = 3'b110,
    ALU_SUBI    = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [31:0] word;
    logic        illegal;
  } enc_result_t;

  // Illegal codes collapse to the NOOP word so the address stream stays gap-free.
  function automatic enc_result_t encode_op(
    input logic [2:0]  code,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] imm
  );
    enc_result_t r;
    r.word    = NOOP_WORD;
    r.illegal = 1'b0;
    case (alu_op_e'(code))
      ALU_NOOP:   r.word = NOOP_WORD;
      ALU_ADD:    r.word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
      ALU_SUB:    r.word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
      ALU_SHIFTL: r.word = {F7_BASE, rs2, rs1, F3_SLL,     rd, OPC_OP};
      ALU_SHIFTR: r.word = {F7_BASE, rs2, rs1, F3_SRL,     rd, OPC_OP};
      ALU_ADDI:   r.word = {imm, rs1, F3_ADDI, rd, OPC_OP_IMM};
      ALU_SUBI:   r.word = {imm, rs1, F3_SUBI, rd, OPC_OP_IMM};
      default: begin
        r.word    = NOOP_WORD;
        r.illegal = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_enc_skid.sv
// rtl/instr_enc_skid.sv - 2-entry valid/ready buffer with registered input ready
// Ready depends only on occupancy, so there is no path from out_ready_i to in_ready_o.
module instr_enc_skid #(
  parameter int W = 40
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         ready_q;
  logic         push, pop;

  assign push = in_valid_i & ready_q;
  assign pop  = (count_q != 2'd0) & out_ready_i;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ready_q  <= (count_d != 2'd2);
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - ALU-op request to RV32 word encoder with address tagging
// Optional INSTR_ENC_X0_GUARD_EN: non-NOOP ops targeting x0 become NOOP and flag err.
module instruction_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [11:0]       imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              err,
  input  logic              err_clr,
  output logic              addr_wrap
);

  localparam int DW = 32 + ADDR_W;

  enc_result_t       enc;
  logic              x0_hit;
  logic [31:0]       word;
  logic              accept;
  logic              err_set;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              err_q, err_d;
  logic              wrap_q, wrap_d;
  logic [DW-1:0]     out_data;

  assign enc = encode_op(op_code, rd, rs1, rs2, imm);

`ifdef INSTR_ENC_X0_GUARD_EN
  assign x0_hit = (op_code != ALU_NOOP) && !enc.illegal && (rd == 5'd0);
`else
  assign x0_hit = 1'b0;
`endif

  assign word    = x0_hit ? NOOP_WORD : enc.word;
  assign accept  = op_valid & op_ready;
  assign err_set = accept & (enc.illegal | x0_hit);

  always_comb begin
    wr_addr_d = wr_addr_q;
    wrap_d    = wrap_q;
    err_d     = err_q & ~err_clr;
    if (err_set) begin
      err_d = 1'b1;
    end
    if (accept) begin
      wr_addr_d = wr_addr_q + 1'b1;
      if (&wr_addr_q) begin
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
    end
  end

  instr_enc_skid #(
    .W(DW)
  ) u_skid (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (op_valid),
    .in_ready_o  (op_ready),
    .in_data_i   ({word, wr_addr_q}),
    .out_valid_o (instr_valid),
    .out_ready_i (instr_ready),
    .out_data_o  (out_data)
  );

  assign instr      = out_data[DW-1:ADDR_W];
  assign instr_addr = out_data[ADDR_W-1:0];
  assign err        = err_q;
  assign addr_wrap  = wrap_q;

endmodule
